// File: rtl/mem_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_bist_ctrl_if
//   Valid/ready request bus between the BIST controller and a single-port
//   memory. One transfer happens on every posedge where valid & ready.
//   Read data is returned in the cycle after the read transfer edge.
//
//   Parameters
//     WIDTH  memory data width
//     ADDR   memory address width
//
//   Signals
//     mem_valid_o  request valid             (controller -> memory)
//     mem_wr_rd_o  1 = write, 0 = read       (controller -> memory)
//     mem_addr_o   request address           (controller -> memory)
//     mem_wdata_o  write data                (controller -> memory)
//     mem_ready_i  memory ready              (memory -> controller)
//     mem_rdata_i  read data, one cycle late (memory -> controller)
//
//   Modports
//     master  controller side
//     slave   memory side
// ---------------------------------------------------------------------------
interface mem_bist_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int ADDR  = 5
);
    logic             mem_valid_o;
    logic             mem_wr_rd_o;
    logic [ADDR-1:0]  mem_addr_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic             mem_ready_i;
    logic [WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_valid_o,
        output mem_wr_rd_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ready_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_valid_o,
        input  mem_wr_rd_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ready_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bist_ctrl
//   Built-in self-test controller for a single-port memory. On start it
//   writes a pattern to every address 0..DEPTH-1, then reads every address
//   back and compares each returned word with the regenerated pattern.
//
//   Parameters
//     WIDTH  memory data width
//     DEPTH  memory depth in words (ADDR = $clog2(DEPTH))
//     ERRW   error counter width, saturating at 2**ERRW-1
//
//   Ports
//     clk_i        clock, all logic on posedge
//     rst_i        synchronous active-high reset
//     start_i      start pulse, only honoured in IDLE
//     mode_i       pattern select, captured at start
//                    0 walking ones, 1 walking zeros,
//                    2 address-in-data, 3 checkerboard
//     busy_o       high in WRITE / READ / FLUSH
//     done_o       one-cycle pulse at end of run
//     pass_o       last run had no mismatches (held until next start)
//     err_cnt_o    mismatch count of last run (saturating)
//     fail_addr_o  address of first mismatch, 0 if none
//     mem          memory request bus (master side of mem_bist_ctrl_if)
//
//   Build option
//     BIST_STOP_ON_FAIL_EN  when defined, the run stops at the first
//                           mismatch and goes straight to DONE; otherwise
//                           the full sweep always completes.
// ---------------------------------------------------------------------------
module mem_bist_ctrl #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 32,
    parameter  int ERRW  = 8,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [ERRW-1:0] err_cnt_o,
    output logic [ADDR-1:0] fail_addr_o,
    mem_bist_ctrl_if.master mem
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
    localparam logic [ERRW-1:0] ERR_MAX   = '1;

    // Checkerboard base word: every odd-numbered bit set (0xAAA for 12 bits).
    localparam int                           CHK_PAIRS = (WIDTH + 1) / 2;
    localparam logic [2*CHK_PAIRS-1:0]       CHK_REP   = {CHK_PAIRS{2'b10}};
    localparam logic [WIDTH-1:0]             CHK_WORD  = CHK_REP[WIDTH-1:0];
    localparam logic [WIDTH-1:0]             ONE_WORD  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state_q;
    logic [1:0]       mode_q;
    logic [ADDR-1:0]  addr_q;
    logic             cmp_pend_q;
    logic [ADDR-1:0]  cmp_addr_q;
    logic [WIDTH-1:0] cmp_exp_q;
    logic [ERRW-1:0]  err_q;
    logic [ADDR-1:0]  fail_q;
    logic             pass_q;

    logic             accept;
    logic             last_addr;
    logic             mismatch;

    function automatic logic [WIDTH-1:0] pattern(input logic [1:0]      mode,
                                                 input logic [ADDR-1:0] a);
        logic [WIDTH-1:0]      one_hot;
        logic [WIDTH+ADDR-1:0] ext;
        logic [WIDTH-1:0]      p;
        one_hot = ONE_WORD << (int'(a) % WIDTH);
        ext     = {{WIDTH{1'b0}}, a};
        case (mode)
            2'd0:    p = one_hot;
            2'd1:    p = ~one_hot;
            2'd2:    p = ext[WIDTH-1:0];
            default: p = a[0] ? ~CHK_WORD : CHK_WORD;
        endcase
        return p;
    endfunction

    always_comb begin
        accept    = mem.mem_valid_o & mem.mem_ready_i;
        last_addr = (addr_q == LAST_ADDR);
        // Read data for the read accepted last edge is on the bus now.
        mismatch  = cmp_pend_q && (mem.mem_rdata_i != cmp_exp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            addr_q     <= '0;
            cmp_pend_q <= 1'b0;
            cmp_addr_q <= '0;
            cmp_exp_q  <= '0;
            err_q      <= '0;
            fail_q     <= '0;
            pass_q     <= 1'b0;
        end else begin
            // Compare stage: one compare per accepted read, one cycle later.
            if (mismatch) begin
                if (err_q != ERR_MAX) begin
                    err_q <= err_q + 1'b1;
                end
                // err_q saturates and never returns to zero within a run,
                // so zero here means this is the first mismatch.
                if (err_q == '0) begin
                    fail_q <= cmp_addr_q;
                end
            end
            cmp_pend_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_WRITE;
                        mode_q  <= mode_i;
                        addr_q  <= '0;
                        err_q   <= '0;
                        fail_q  <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        if (last_addr) begin
                            addr_q  <= '0;
                            state_q <= S_READ;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (accept) begin
                        cmp_pend_q <= 1'b1;
                        cmp_addr_q <= addr_q;
                        cmp_exp_q  <= pattern(mode_q, addr_q);
                        if (last_addr) begin
                            state_q <= S_FLUSH;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Final read is compared this edge, so fold it in here.
                    pass_q  <= (err_q == '0) && !mismatch;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

`ifdef BIST_STOP_ON_FAIL_EN
            // Overrides the FSM step above: abandon the sweep and drop any
            // read accepted on this same edge without comparing it.
            if (mismatch) begin
                state_q    <= S_DONE;
                cmp_pend_q <= 1'b0;
            end
`else
`endif
        end
    end

    assign busy_o      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_FLUSH);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_q;
    assign fail_addr_o = fail_q;

    // Address and data are forced to zero while no request is outstanding.
    assign mem.mem_valid_o = (state_q == S_WRITE) || (state_q == S_READ);
    assign mem.mem_wr_rd_o = (state_q == S_WRITE);
    assign mem.mem_addr_o  = mem.mem_valid_o ? addr_q : '0;
    assign mem.mem_wdata_o = (state_q == S_WRITE) ? pattern(mode_q, addr_q) : '0;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
module tb_mem_bist_ctrl;

    localparam int WIDTH = 12;
    localparam int DEPTH = 32;
    localparam int ERRW  = 5;
    localparam int ADDR  = 5;
    localparam int ERR_SAT = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [1:0]      mode_i;
    logic            busy_o;
    logic            done_o;
    logic            pass_o;
    logic [ERRW-1:0] err_cnt_o;
    logic [ADDR-1:0] fail_addr_o;

    mem_bist_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    mem_bist_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .err_cnt_o  (err_cnt_o),
        .fail_addr_o(fail_addr_o),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- memory model with fault injection ----------------
    logic [WIDTH-1:0] mem_arr [DEPTH];
    int               fault_addr = -2;          // -2 none, -1 every address
    logic [WIDTH-1:0] fault_mask = '0;
    int               rdy_style  = 0;           // 0 always, 1 toggle, 2 random
    logic             rdy_q      = 1'b1;

    assign bus.mem_ready_i = rdy_q;

    always @(posedge clk) begin
        if (bus.mem_valid_o && bus.mem_ready_i) begin
            if (bus.mem_wr_rd_o)
                mem_arr[bus.mem_addr_o] <= bus.mem_wdata_o;
            else
                bus.mem_rdata_i <= mem_arr[bus.mem_addr_o] |
                    ((fault_addr == -1 || fault_addr == int'(bus.mem_addr_o)) ? fault_mask : '0);
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_style)
            0:       rdy_q = 1'b1;
            1:       rdy_q = ~rdy_q;
            default: rdy_q = 1'($urandom % 2);
        endcase
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        bit               wr;
        int               addr;
        logic [WIDTH-1:0] data;
    } xfer_t;

    xfer_t            xlog[$];
    bit               hp = 0;
    logic             pv, pr, pw;
    logic [ADDR-1:0]  pa;
    logic [WIDTH-1:0] pd;
    int               done_cnt = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            hp = 0;
        end else begin
            if (hp && pv && !pr && bus.mem_valid_o) begin
                check("hold_addr",  32'(bus.mem_addr_o),  32'(pa));
                check("hold_wdata", 32'(bus.mem_wdata_o), 32'(pd));
                check("hold_wr",    32'(bus.mem_wr_rd_o), 32'(pw));
            end
            if (bus.mem_valid_o && bus.mem_ready_i)
                xlog.push_back('{bus.mem_wr_rd_o, int'(bus.mem_addr_o), bus.mem_wdata_o});
            hp = 1;
            pv = bus.mem_valid_o;
            pr = bus.mem_ready_i;
            pw = bus.mem_wr_rd_o;
            pa = bus.mem_addr_o;
            pd = bus.mem_wdata_o;
        end
        if (done_o) done_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [11:0] exp_word(input int mode, input int a);
        logic [11:0] w;
        case (mode)
            0:       w = 12'(1 << (a % 12));
            1:       w = ~12'(1 << (a % 12));
            2:       w = 12'(a);
            default: w = (a % 2 == 1) ? 12'h555 : 12'hAAA;
        endcase
        return w;
    endfunction

    task automatic model(input int mode, input int faddr, input logic [11:0] fmask,
                         output int cnt, output int first);
        logic [11:0] e;
        logic [11:0] rd;
        cnt = 0;
        first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            e  = exp_word(mode, a);
            rd = e | ((faddr == -1 || faddr == a) ? fmask : 12'h000);
            if (rd != e) begin
                if (cnt == 0) first = a;
                cnt++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy_o), 0);
        check({tag, "_done"},  32'(done_o), 0);
        check({tag, "_pass"},  32'(pass_o), 0);
        check({tag, "_err"},   32'(err_cnt_o), 0);
        check({tag, "_faddr"}, 32'(fail_addr_o), 0);
        check({tag, "_valid"}, 32'(bus.mem_valid_o), 0);
        check({tag, "_wr"},    32'(bus.mem_wr_rd_o), 0);
        check({tag, "_addr"},  32'(bus.mem_addr_o), 0);
        check({tag, "_wdata"}, 32'(bus.mem_wdata_o), 0);
    endtask

    // One complete run; exp_lat 0 means latency is not checked.
    task automatic do_run(input string tag, input int mode, input int rdy, input int faddr,
                          input logic [11:0] fmask, input bit disturb, input bit exp_pass,
                          input int exp_err, input int exp_fail, input int exp_lat);
        int cyc;
        int d0;
        int cnt;
        int first;
        int bad_idx;
        int max_rd;
        bit stopped;
        model(mode, faddr, fmask, cnt, first);
        stopped = 0;
`ifdef BIST_STOP_ON_FAIL_EN
        stopped = (cnt > 0);
`endif
        fault_addr = faddr;
        fault_mask = fmask;
        rdy_style  = rdy;
        @(negedge clk);
        xlog.delete();
        d0 = done_cnt;
        start_i = 1'b1;
        mode_i  = 2'(mode);
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = ~2'(mode);
        check({tag, "_busy_start"}, 32'(busy_o), 1);
        check({tag, "_err_clr"},    32'(err_cnt_o), 0);
        check({tag, "_pass_clr"},   32'(pass_o), 0);
        cyc = 0;
        while (!done_o && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (disturb) begin
                if (cyc == 20 || cyc == 45) begin start_i = 1'b1; mode_i = 2'd2; end
                if (cyc == 21 || cyc == 46) start_i = 1'b0;
            end
        end
        check({tag, "_timeout"}, 32'(done_o), 1);
        if (exp_lat != 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_pass"},       32'(pass_o), 32'(exp_pass));
        check({tag, "_err"},        32'(err_cnt_o), 32'(exp_err));
        check({tag, "_faddr"},      32'(fail_addr_o), 32'(exp_fail));
        check({tag, "_valid_done"}, 32'(bus.mem_valid_o), 0);
        if (disturb) start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_done_pulse"}, 32'(done_o), 0);
        check({tag, "_idle"},       32'(busy_o), 0);
        check({tag, "_pass_held"},  32'(pass_o), 32'(exp_pass));
        check({tag, "_done_cnt"},   32'(done_cnt - d0), 1);
        if (!stopped) begin
            check({tag, "_nxfer"}, 32'(xlog.size()), 32'(2 * DEPTH));
            bad_idx = -1;
            for (int i = 0; i < xlog.size() && i < 2 * DEPTH; i++) begin
                if (bad_idx < 0 &&
                    ((i < DEPTH && (!xlog[i].wr || xlog[i].addr != i ||
                                    xlog[i].data !== exp_word(mode, i))) ||
                     (i >= DEPTH && (xlog[i].wr || xlog[i].addr != i - DEPTH))))
                    bad_idx = i;
            end
            check({tag, "_xfer_order"}, 32'(bad_idx), 32'(-1));
            if (mode == 0) check({tag, "_wd13"}, 32'(xlog[13].data), 32'h002);
            if (mode == 3) begin
                check({tag, "_wd4"}, 32'(xlog[4].data), 32'hAAA);
                check({tag, "_wd5"}, 32'(xlog[5].data), 32'h555);
            end
        end else begin
            max_rd = 0;
            foreach (xlog[i]) if (!xlog[i].wr && xlog[i].addr > max_rd) max_rd = xlog[i].addr;
            check({tag, "_stop_rd_max"}, 32'(max_rd <= first + 1), 1);
        end
        fault_addr = -2;
        rdy_style  = 0;
    endtask

    typedef struct {
        int          mode;
        int          rdy;
        int          faddr;
        logic [11:0] fmask;
        bit          disturb;
        bit          exp_pass;
        int          exp_err;
        int          exp_fail;
        int          exp_lat;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int cyc;
        int cnt;
        int first;
        int e_err;
        int e_lat;
        int m;
        int r;
        int k;
        int fa;
        logic [11:0] fm;

        tbl[0]  = '{0, 0, -2, 12'h000, 0, 1, 0,  0,  65};
        tbl[1]  = '{3, 1, -2, 12'h000, 0, 1, 0,  0,  0};
        tbl[2]  = '{0, 0,  7, 12'h008, 0, 0, 1,  7,  65};
        tbl[3]  = '{0, 0, -2, 12'h000, 1, 1, 0,  0,  65};
        tbl[4]  = '{1, 0,  0, 12'h001, 0, 0, 1,  0,  65};
        tbl[5]  = '{2, 0, 31, 12'h800, 0, 0, 1,  31, 65};
        tbl[6]  = '{0, 0, -1, 12'h001, 0, 0, 29, 1,  65};
        tbl[7]  = '{1, 0, -1, 12'hFFF, 0, 0, 31, 0,  65};
        tbl[8]  = '{2, 2, -2, 12'h000, 0, 1, 0,  0,  0};
        tbl[9]  = '{3, 0,  5, 12'h555, 0, 1, 0,  0,  65};
        tbl[10] = '{3, 1,  4, 12'h001, 0, 0, 1,  4,  0};

        rst_i   = 1'b1;
        start_i = 1'b0;
        mode_i  = 2'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            e_err = tbl[i].exp_err;
            e_lat = tbl[i].exp_lat;
`ifdef BIST_STOP_ON_FAIL_EN
            if (e_err > 0) begin e_err = 1; e_lat = 0; end
`endif
            do_run($sformatf("vec%0d", i), tbl[i].mode, tbl[i].rdy, tbl[i].faddr, tbl[i].fmask,
                   tbl[i].disturb, tbl[i].exp_pass, e_err, tbl[i].exp_fail, e_lat);
        end

        // Reset in the middle of the read sweep, with errors already counted.
        fault_addr = -1;
        fault_mask = 12'h001;
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = 2'd0;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (!(bus.mem_valid_o && !bus.mem_wr_rd_o && bus.mem_addr_o == 5'd10) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_rd10", 32'(bus.mem_addr_o), 10);
        check("mid_err_nonzero", 32'(err_cnt_o != '0), 1);
        rst_i = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst_i = 1'b0;
        fault_addr = -2;
        do_run("after_rst", 1, 0, -2, 12'h000, 0, 1, 0, 0, 65);

        // Randomized runs against the reference model.
        for (int n = 0; n < 8; n++) begin
            m = int'($urandom % 4);
            r = int'($urandom % 3);
            k = int'($urandom % 3);
            fa = -2;
            fm = 12'h000;
            if (k == 1) begin
                fa = int'($urandom % DEPTH);
                fm = 12'($urandom % 4096);
            end else if (k == 2) begin
                fa = -1;
                fm = 12'(1 << ($urandom % 12));
            end
            model(m, fa, fm, cnt, first);
            e_err = (cnt > ERR_SAT) ? ERR_SAT : cnt;
            e_lat = (r == 0) ? 65 : 0;
`ifdef BIST_STOP_ON_FAIL_EN
            if (cnt > 0) begin e_err = 1; e_lat = 0; end
`endif
            do_run($sformatf("rnd%0d", n), m, r, fa, fm, 0, cnt == 0, e_err, first, e_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
